lc3_control_fsm: RTL and testbench

- Moore state machine that sequences the 16-bit CPU datapath (PC, IR, MAR and MDR registers, bus gates, PCMUX, ADDR2MUX, ALUK) through fetch, decode and execute.
- Also drives the register-file and memory strobes.
- Memory wait states are counted internally, so datapath loads line up with the memory access time.
- Sits beside the datapath in the CPU top; every datapath control input comes from this block.

---
 rtl/lc3_control_fsm_if.sv | 34 +++
 rtl/lc3_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_control_fsm_if.sv
// Control bundle between the LC-3 control FSM (master) and the CPU datapath (slave):
// run/continue handshake, instruction/branch status in, every datapath control out.
interface lc3_control_fsm_if;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;

    logic        LD_PC, LD_IR, LD_MAR, LD_MDR, LD_REG, LD_CC, LD_BEN;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX;
    logic [1:0]  ADDR2MUX;
    logic        ADDR1MUX;
    logic [1:0]  ALUK;
    logic        DRMUX, SR1MUX, SR2MUX;
    logic        MIO_EN, Mem_OE, Mem_WE;
    logic [4:0]  State_Out;

    modport master (
        input  Run, Continue, IR, BEN,
        output LD_PC, LD_IR, LD_MAR, LD_MDR, LD_REG, LD_CC, LD_BEN,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, ADDR2MUX, ADDR1MUX, ALUK, DRMUX, SR1MUX, SR2MUX,
        output MIO_EN, Mem_OE, Mem_WE, State_Out
    );

    modport slave (
        output Run, Continue, IR, BEN,
        input  LD_PC, LD_IR, LD_MAR, LD_MDR, LD_REG, LD_CC, LD_BEN,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, ADDR2MUX, ADDR1MUX, ALUK, DRMUX, SR1MUX, SR2MUX,
        input  MIO_EN, Mem_OE, Mem_WE, State_Out
    );
endinterface

// File: rtl/lc3_control_fsm.sv
// LC-3 control unit: Moore FSM sequencing fetch/decode/execute with counted memory wait states.
// Optional JSR/JSRR support (opcode 0100) is compiled in when LC3_JSR_EN is defined.
module lc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic               Clk,
    input  logic               Reset_al,
    lc3_control_fsm_if.master  ctl
);

    localparam int unsigned   CW       = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        S_HALTED  = 5'd0,
        S_FETCH1  = 5'd1,
        S_FETCH2  = 5'd2,
        S_FETCH3  = 5'd3,
        S_DECODE  = 5'd4,
        S_ADD     = 5'd5,
        S_AND     = 5'd6,
        S_NOT     = 5'd7,
        S_BR      = 5'd8,
        S_BR_TAKE = 5'd9,
        S_JMP     = 5'd10,
        S_LDR1    = 5'd11,
        S_LDR2    = 5'd12,
        S_LDR3    = 5'd13,
        S_STR1    = 5'd14,
        S_STR2    = 5'd15,
        S_STR3    = 5'd16,
        S_PAUSE1  = 5'd17,
        S_PAUSE2  = 5'd18
`ifdef LC3_JSR_EN
        ,
        S_JSR1    = 5'd19,
        S_JSR2    = 5'd20
`endif
    } state_t;

    typedef struct packed {
        logic       ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic       addr1mux;
        logic [1:0] aluk;
        logic       drmux, sr1mux, sr2mux;
        logic       mio_en, mem_oe, mem_we;
    } ctrl_t;

    // PC+1 is the resting PCMUX select; every other control idles low.
    localparam ctrl_t RESET_CTRL = '{pcmux: 2'b10, default: '0};

    state_t        state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    ctrl_t         ctrl, next_ctrl;

    logic unused_ir_bits;
    assign unused_ir_bits = ^ctl.IR;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        next_state = state;
        next_cnt   = '0;
        case (state)
            S_HALTED:  if (ctl.Run) next_state = S_FETCH1;
            S_FETCH1:  next_state = S_FETCH2;
            S_FETCH2:  if (cnt == CNT_LAST) next_state = S_FETCH3;
                       else                 next_cnt   = cnt + 1'b1;
            S_FETCH3:  next_state = S_DECODE;
            S_DECODE: begin
                case (ctl.IR[15:12])
                    4'b0001: next_state = S_ADD;
                    4'b0101: next_state = S_AND;
                    4'b1001: next_state = S_NOT;
                    4'b0000: next_state = S_BR;
                    4'b1100: next_state = S_JMP;
                    4'b0110: next_state = S_LDR1;
                    4'b0111: next_state = S_STR1;
                    4'b1101: next_state = S_PAUSE1;
`ifdef LC3_JSR_EN
                    4'b0100: next_state = S_JSR1;
`endif
                    default: next_state = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_LDR3:
                       next_state = S_FETCH1;
            S_BR:      next_state = ctl.BEN ? S_BR_TAKE : S_FETCH1;
            S_LDR1:    next_state = S_LDR2;
            S_LDR2:    if (cnt == CNT_LAST) next_state = S_LDR3;
                       else                 next_cnt   = cnt + 1'b1;
            S_STR1:    next_state = S_STR2;
            S_STR2:    next_state = S_STR3;
            S_STR3:    if (cnt == CNT_LAST) next_state = S_FETCH1;
                       else                 next_cnt   = cnt + 1'b1;
            S_PAUSE1:  if (ctl.Continue)  next_state = S_PAUSE2;
            S_PAUSE2:  if (!ctl.Continue) next_state = S_FETCH1;
`ifdef LC3_JSR_EN
            S_JSR1:    next_state = S_JSR2;
            S_JSR2:    next_state = S_FETCH1;
`endif
            default:   next_state = S_HALTED;
        endcase
    end

    // Controls are decoded from the state being entered so the registered copy belongs to it.
    always_comb begin
        next_ctrl = RESET_CTRL;
        case (next_state)
            S_FETCH1: begin
                next_ctrl.gate_pc = 1'b1;
                next_ctrl.ld_mar  = 1'b1;
                next_ctrl.ld_pc   = 1'b1;
            end
            S_FETCH2, S_LDR2: begin
                next_ctrl.mem_oe = 1'b1;
                next_ctrl.mio_en = 1'b1;
                next_ctrl.ld_mdr = (next_cnt == CNT_LAST);
            end
            S_FETCH3: begin
                next_ctrl.gate_mdr = 1'b1;
                next_ctrl.ld_ir    = 1'b1;
            end
            S_DECODE: next_ctrl.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                next_ctrl.gate_alu = 1'b1;
                next_ctrl.ld_reg   = 1'b1;
                next_ctrl.ld_cc    = 1'b1;
                next_ctrl.sr1mux   = 1'b1;
                next_ctrl.sr2mux   = ctl.IR[5];
                next_ctrl.aluk     = (next_state == S_ADD) ? 2'b00 :
                                     (next_state == S_AND) ? 2'b01 : 2'b10;
            end
            S_BR_TAKE: begin
                next_ctrl.addr2mux = 2'b10;
                next_ctrl.pcmux    = 2'b01;
                next_ctrl.ld_pc    = 1'b1;
            end
            S_JMP: begin
                next_ctrl.addr1mux = 1'b1;
                next_ctrl.pcmux    = 2'b01;
                next_ctrl.ld_pc    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                next_ctrl.gate_marmux = 1'b1;
                next_ctrl.addr1mux    = 1'b1;
                next_ctrl.addr2mux    = 2'b01;
                next_ctrl.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                next_ctrl.gate_mdr = 1'b1;
                next_ctrl.ld_reg   = 1'b1;
                next_ctrl.ld_cc    = 1'b1;
            end
            S_STR2: begin
                next_ctrl.aluk     = 2'b11;
                next_ctrl.gate_alu = 1'b1;
                next_ctrl.ld_mdr   = 1'b1;
            end
            S_STR3: next_ctrl.mem_we = 1'b1;
`ifdef LC3_JSR_EN
            S_JSR1: begin
                next_ctrl.gate_pc = 1'b1;
                next_ctrl.drmux   = 1'b1;
                next_ctrl.ld_reg  = 1'b1;
            end
            S_JSR2: begin
                next_ctrl.pcmux    = 2'b01;
                next_ctrl.ld_pc    = 1'b1;
                next_ctrl.addr1mux = ~ctl.IR[11];
                next_ctrl.addr2mux = ctl.IR[11] ? 2'b11 : 2'b00;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; async reset clears strobes (incl. Mem_WE) at once.
    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state <= S_HALTED;
            cnt   <= '0;
            ctrl  <= RESET_CTRL;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            ctrl  <= next_ctrl;
        end
    end

    assign ctl.LD_PC      = ctrl.ld_pc;
    assign ctl.LD_IR      = ctrl.ld_ir;
    assign ctl.LD_MAR     = ctrl.ld_mar;
    assign ctl.LD_MDR     = ctrl.ld_mdr;
    assign ctl.LD_REG     = ctrl.ld_reg;
    assign ctl.LD_CC      = ctrl.ld_cc;
    assign ctl.LD_BEN     = ctrl.ld_ben;
    assign ctl.GatePC     = ctrl.gate_pc;
    assign ctl.GateMDR    = ctrl.gate_mdr;
    assign ctl.GateALU    = ctrl.gate_alu;
    assign ctl.GateMARMUX = ctrl.gate_marmux;
    assign ctl.PCMUX      = ctrl.pcmux;
    assign ctl.ADDR2MUX   = ctrl.addr2mux;
    assign ctl.ADDR1MUX   = ctrl.addr1mux;
    assign ctl.ALUK       = ctrl.aluk;
    assign ctl.DRMUX      = ctrl.drmux;
    assign ctl.SR1MUX     = ctrl.sr1mux;
    assign ctl.SR2MUX     = ctrl.sr2mux;
    assign ctl.MIO_EN     = ctrl.mio_en;
    assign ctl.Mem_OE     = ctrl.mem_oe;
    assign ctl.Mem_WE     = ctrl.mem_we;
    assign ctl.State_Out  = state;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: instruction walk table on a MEM_WAIT=2 instance,
// plus hand sequences for reset, PAUSE and a MEM_WAIT=3 store on a second instance.
module tb_lc3_control_fsm;

    localparam int S_HALTED = 0,  S_FETCH1 = 1,  S_FETCH2 = 2,  S_FETCH3 = 3,  S_DECODE = 4;
    localparam int S_ADD    = 5,  S_AND    = 6,  S_NOT    = 7,  S_BR     = 8,  S_BR_TAKE = 9;
    localparam int S_JMP    = 10, S_LDR1   = 11, S_LDR2   = 12, S_LDR3   = 13, S_STR1    = 14;
    localparam int S_STR2   = 15, S_STR3   = 16, S_PAUSE1 = 17, S_PAUSE2 = 18;
    localparam int S_JSR1   = 19, S_JSR2   = 20;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic        ben;
        int          seq [12];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst2_n, rst3_n;
    logic        run, cont, ben;
    logic [15:0] ir;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    lc3_control_fsm_if bus2 ();
    lc3_control_fsm_if bus3 ();

    assign bus2.Run = run;  assign bus2.Continue = cont;  assign bus2.IR = ir;  assign bus2.BEN = ben;
    assign bus3.Run = run;  assign bus3.Continue = cont;  assign bus3.IR = ir;  assign bus3.BEN = ben;

    lc3_control_fsm #(.MEM_WAIT(2)) dut2 (.Clk(clk), .Reset_al(rst2_n), .ctl(bus2));
    lc3_control_fsm #(.MEM_WAIT(3)) dut3 (.Clk(clk), .Reset_al(rst3_n), .ctl(bus3));

    logic [23:0] obs2, obs3;
    assign obs2 = {bus2.LD_PC, bus2.LD_IR, bus2.LD_MAR, bus2.LD_MDR, bus2.LD_REG, bus2.LD_CC, bus2.LD_BEN,
                   bus2.GatePC, bus2.GateMDR, bus2.GateALU, bus2.GateMARMUX, bus2.PCMUX, bus2.ADDR2MUX,
                   bus2.ADDR1MUX, bus2.ALUK, bus2.DRMUX, bus2.SR1MUX, bus2.SR2MUX,
                   bus2.MIO_EN, bus2.Mem_OE, bus2.Mem_WE};
    assign obs3 = {bus3.LD_PC, bus3.LD_IR, bus3.LD_MAR, bus3.LD_MDR, bus3.LD_REG, bus3.LD_CC, bus3.LD_BEN,
                   bus3.GatePC, bus3.GateMDR, bus3.GateALU, bus3.GateMARMUX, bus3.PCMUX, bus3.ADDR2MUX,
                   bus3.ADDR1MUX, bus3.ALUK, bus3.DRMUX, bus3.SR1MUX, bus3.SR2MUX,
                   bus3.MIO_EN, bus3.Mem_OE, bus3.Mem_WE};

    // Reference control word for a state, in the same bit order as obs2/obs3.
    function automatic logic [23:0] exp_ctrl(input int st, input bit last, input logic [15:0] cur_ir);
        logic       ld_pc = 0, ld_ir = 0, ld_mar = 0, ld_mdr = 0, ld_reg = 0, ld_cc = 0, ld_ben = 0;
        logic       g_pc = 0, g_mdr = 0, g_alu = 0, g_marmux = 0;
        logic [1:0] pcmux = 2'b10, addr2 = 2'b00, aluk = 2'b00;
        logic       addr1 = 0, drmux = 0, sr1 = 0, sr2 = 0, mio = 0, oe = 0, we = 0;
        case (st)
            S_FETCH1:  begin g_pc = 1; ld_mar = 1; ld_pc = 1; end
            S_FETCH2, S_LDR2: begin oe = 1; mio = 1; ld_mdr = last; end
            S_FETCH3:  begin g_mdr = 1; ld_ir = 1; end
            S_DECODE:  ld_ben = 1;
            S_ADD:     begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; sr2 = cur_ir[5]; aluk = 2'b00; end
            S_AND:     begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; sr2 = cur_ir[5]; aluk = 2'b01; end
            S_NOT:     begin g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1; sr2 = cur_ir[5]; aluk = 2'b10; end
            S_BR_TAKE: begin addr1 = 0; addr2 = 2'b10; pcmux = 2'b01; ld_pc = 1; end
            S_JMP:     begin addr1 = 1; addr2 = 2'b00; pcmux = 2'b01; ld_pc = 1; end
            S_LDR1, S_STR1: begin g_marmux = 1; addr1 = 1; addr2 = 2'b01; ld_mar = 1; end
            S_LDR3:    begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
            S_STR2:    begin sr1 = 0; aluk = 2'b11; g_alu = 1; mio = 0; ld_mdr = 1; end
            S_STR3:    we = 1;
            S_JSR1:    begin g_pc = 1; drmux = 1; ld_reg = 1; end
            S_JSR2:    begin pcmux = 2'b01; ld_pc = 1; addr1 = !cur_ir[11]; addr2 = cur_ir[11] ? 2'b11 : 2'b00; end
            default:   ;
        endcase
        return {ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben, g_pc, g_mdr, g_alu, g_marmux,
                pcmux, addr2, addr1, aluk, drmux, sr1, sr2, mio, oe, we};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Walk one instruction from FETCH1, checking state and full control word every cycle.
    task automatic run_vec(input vec_t v, input bit on3);
        int   mw    = on3 ? 3 : 2;
        int   prev  = S_FETCH1;
        int   wcnt  = 0;
        int   st_act;
        logic [23:0] o_act;
        ir  = v.ir;
        ben = v.ben;
        for (int i = 0; i < 12 && v.seq[i] >= 0; i++) begin
            @(posedge clk); #1;
            if (v.seq[i] == prev && (prev == S_FETCH2 || prev == S_LDR2 || prev == S_STR3)) wcnt++;
            else wcnt = 0;
            st_act = on3 ? int'(bus3.State_Out) : int'(bus2.State_Out);
            o_act  = on3 ? obs3 : obs2;
            check($sformatf("%s state[%0d]", v.name, i), st_act, v.seq[i]);
            check($sformatf("%s ctrl[%0d]", v.name, i), o_act, exp_ctrl(v.seq[i], wcnt == mw - 1, v.ir));
            prev = v.seq[i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end of test within time limit");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;

        v.name = "ADD";     v.ir = 16'h1042; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_ADD, S_FETCH1, -1, -1, -1, -1, -1, -1};   vecs.push_back(v);
        v.name = "AND_imm"; v.ir = 16'h5260; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_AND, S_FETCH1, -1, -1, -1, -1, -1, -1};   vecs.push_back(v);
        v.name = "NOT";     v.ir = 16'h927F; v.ben = 1;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_NOT, S_FETCH1, -1, -1, -1, -1, -1, -1};   vecs.push_back(v);
        v.name = "BR_nt";   v.ir = 16'h0A05; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_BR, S_FETCH1, -1, -1, -1, -1, -1, -1};    vecs.push_back(v);
        v.name = "BR_t";    v.ir = 16'h0A05; v.ben = 1;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_BR, S_BR_TAKE, S_FETCH1, -1, -1, -1, -1, -1}; vecs.push_back(v);
        v.name = "JMP";     v.ir = 16'hC1C0; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_JMP, S_FETCH1, -1, -1, -1, -1, -1, -1};   vecs.push_back(v);
        v.name = "LDR";     v.ir = 16'h6283; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_LDR1, S_LDR2, S_LDR2, S_LDR3, S_FETCH1, -1, -1, -1}; vecs.push_back(v);
        v.name = "STR_w2";  v.ir = 16'h7283; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_STR1, S_STR2, S_STR3, S_STR3, S_FETCH1, -1, -1, -1}; vecs.push_back(v);
        v.name = "NOP_trap"; v.ir = 16'hF025; v.ben = 1;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_FETCH1, -1, -1, -1, -1, -1, -1, -1};       vecs.push_back(v);
`ifdef LC3_JSR_EN
        v.name = "JSR";     v.ir = 16'h4803; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_JSR1, S_JSR2, S_FETCH1, -1, -1, -1, -1, -1}; vecs.push_back(v);
        v.name = "JSRR";    v.ir = 16'h4080; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_JSR1, S_JSR2, S_FETCH1, -1, -1, -1, -1, -1}; vecs.push_back(v);
`else
        v.name = "JSR_nop"; v.ir = 16'h4803; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_FETCH1, -1, -1, -1, -1, -1, -1, -1};       vecs.push_back(v);
`endif

        rst2_n = 0; rst3_n = 0; run = 0; cont = 0; ben = 0; ir = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", bus2.State_Out, S_HALTED);
        check("reset ctrl",  obs2, exp_ctrl(S_HALTED, 0, ir));
        check("reset pcmux", bus2.PCMUX, 2'b10);

        rst2_n = 1;
        repeat (3) @(posedge clk);
        #1;
        check("halted idle", bus2.State_Out, S_HALTED);

        run = 1;
        @(posedge clk); #1;
        check("run state", bus2.State_Out, S_FETCH1);
        check("run ctrl",  obs2, exp_ctrl(S_FETCH1, 0, ir));

        // Run stays high through the table; outside HALTED it must have no effect.
        foreach (vecs[k]) run_vec(vecs[k], 1'b0);
        run = 0;

        // Asynchronous reset in the middle of an instruction fetch.
        ir = 16'h1042;
        @(posedge clk); #1;
        check("pre-reset fetch2", bus2.State_Out, S_FETCH2);
        rst2_n = 0;
        #1;
        check("midfetch reset state", bus2.State_Out, S_HALTED);
        check("midfetch reset ctrl",  obs2, exp_ctrl(S_HALTED, 0, ir));
        #1 rst2_n = 1;
        @(posedge clk); #1;
        check("post-reset halted", bus2.State_Out, S_HALTED);
        run = 1;
        @(posedge clk); #1;
        run = 0;
        check("restart state", bus2.State_Out, S_FETCH1);
        check("restart ctrl",  obs2, exp_ctrl(S_FETCH1, 0, ir));

        // PAUSE: wait for Continue high, then for it to drop.
        v.name = "PAUSE";   v.ir = 16'hD0FF; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_PAUSE1, -1, -1, -1, -1, -1, -1, -1};
        run_vec(v, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("pause1 hold[%0d]", i), bus2.State_Out, S_PAUSE1);
        end
        cont = 1;
        @(posedge clk); #1;
        check("pause2 entry", bus2.State_Out, S_PAUSE2);
        @(posedge clk); #1;
        check("pause2 hold", bus2.State_Out, S_PAUSE2);
        cont = 0;
        @(posedge clk); #1;
        check("pause exit", bus2.State_Out, S_FETCH1);
        check("pause exit ctrl", obs2, exp_ctrl(S_FETCH1, 0, ir));

        // MEM_WAIT=3 instance: full store, then a reset landing on the second write cycle.
        rst2_n = 0;
        rst3_n = 1;
        @(posedge clk); #1;
        check("w3 halted", bus3.State_Out, S_HALTED);
        run = 1;
        @(posedge clk); #1;
        run = 0;
        check("w3 run state", bus3.State_Out, S_FETCH1);

        v.name = "STR_w3";  v.ir = 16'h7283; v.ben = 0;
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_STR1, S_STR2, S_STR3, S_STR3, S_STR3, S_FETCH1, -1};
        run_vec(v, 1'b1);

        v.name = "STR_w3_rst";
        v.seq = '{S_FETCH2, S_FETCH2, S_FETCH2, S_FETCH3, S_DECODE, S_STR1, S_STR2, S_STR3, S_STR3, -1, -1, -1};
        run_vec(v, 1'b1);
        check("midwrite Mem_WE before reset", bus3.Mem_WE, 1'b1);
        rst3_n = 0;
        #1;
        check("midwrite Mem_WE after reset", bus3.Mem_WE, 1'b0);
        check("midwrite reset state", bus3.State_Out, S_HALTED);
        check("midwrite reset ctrl",  obs3, exp_ctrl(S_HALTED, 0, ir));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
